// File: rtl/axi_arb_pkg.sv
// Shared types for the LPDDR AXI read arbiter: AR/R payload structs and the FSM states.
// Field widths come from the AXI_*_WIDTH macros, with defaults when they are not defined globally.
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_LEN_WIDTH
`define AXI_LEN_WIDTH 8
`endif
`ifndef AXI_SIZE_WIDTH
`define AXI_SIZE_WIDTH 3
`endif
`ifndef AXI_BURST_WIDTH
`define AXI_BURST_WIDTH 2
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif
`ifndef AXI_RESP_WIDTH
`define AXI_RESP_WIDTH 2
`endif

package axi_arb_pkg;

  localparam int BEAT_W = 8;

  typedef struct packed {
    logic [`AXI_ID_WIDTH-1:0]    id;
    logic [`AXI_ADDR_WIDTH-1:0]  addr;
    logic [`AXI_LEN_WIDTH-1:0]   len;
    logic [`AXI_SIZE_WIDTH-1:0]  size;
    logic [`AXI_BURST_WIDTH-1:0] burst;
  } ar_t;

  typedef struct packed {
    logic [`AXI_ID_WIDTH-1:0]   id;
    logic [`AXI_DATA_WIDTH-1:0] data;
    logic [`AXI_RESP_WIDTH-1:0] resp;
    logic                       last;
  } r_t;

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_e;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin select: lowest requesting index at or above ptr_i, wrapping to 0.
// Shared between the read arbiter and the write-side arbiter.
module rr_picker #(
  parameter int NUM_REQ = 2,
  localparam int GNT_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [GNT_W-1:0]   ptr_i,
  output logic [GNT_W-1:0]   idx_o,
  output logic               found_o
);

  // First pass covers ptr_i..top, second pass supplies the wrapped candidates.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!found_o && req_i[j] && (GNT_W'(j) >= ptr_i)) begin
        found_o = 1'b1;
        idx_o   = GNT_W'(j);
      end
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!found_o && req_i[j]) begin
        found_o = 1'b1;
        idx_o   = GNT_W'(j);
      end
    end
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Round-robin arbiter sharing the LPDDR controller AXI read port, one outstanding burst at a time.
// Define AXI_RD_ARB_TIMEOUT_EN to add the burst watchdog and the sticky timeout output.
module axi_rd_arbiter
  import axi_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
`ifdef AXI_RD_ARB_TIMEOUT_EN
  parameter int TIMEOUT = 1024,
`endif
  localparam int GNT_W = $clog2(NUM_REQ)
) (
  input  logic               aclk,
  input  logic               aresetn,
  input  logic [NUM_REQ-1:0] s_arvalid,
  output logic [NUM_REQ-1:0] s_arready,
  input  ar_t                s_ar [NUM_REQ],
  output logic [NUM_REQ-1:0] s_rvalid,
  input  logic [NUM_REQ-1:0] s_rready,
  output r_t                 s_r,
  output logic               m_arvalid,
  input  logic               m_arready,
  output ar_t                m_ar,
  input  logic               m_rvalid,
  output logic               m_rready,
  input  r_t                 m_r,
  output logic [GNT_W-1:0]   gnt_idx,
  output logic               len_err
`ifdef AXI_RD_ARB_TIMEOUT_EN
  ,
  output logic               timeout
`endif
);

  state_e             state_q, state_d;
  logic [GNT_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [GNT_W-1:0]   gnt_q, gnt_d;
  ar_t                ar_q, ar_d;
  logic [BEAT_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic               len_err_q, len_err_d;
  logic [GNT_W-1:0]   pick_idx, ptr_next;
  logic               pick_found, r_hs, len_match;

`ifdef AXI_RD_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             timeout_q, timeout_d;
  logic             absorb_q, absorb_d;
  assign timeout = timeout_q;
`endif

  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req_i   (s_arvalid),
    .ptr_i   (rr_ptr_q),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  assign ptr_next  = (gnt_q == GNT_W'(NUM_REQ - 1)) ? '0 : gnt_q + 1'b1;
  assign r_hs      = m_rvalid && s_rready[gnt_q];
  assign len_match = (beat_cnt_q == BEAT_W'(ar_q.len));
  assign gnt_idx   = gnt_q;
  assign len_err   = len_err_q;

  // Grant is combinational in IDLE so the requester sees s_arready in the cycle it is chosen;
  // gating with aresetn keeps every output low while reset is held.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    gnt_d      = gnt_q;
    ar_d       = ar_q;
    beat_cnt_d = beat_cnt_q;
    len_err_d  = len_err_q;
    s_arready  = '0;
    s_rvalid   = '0;
    s_r        = '0;
    m_arvalid  = 1'b0;
    m_ar       = ar_q;
    m_rready   = 1'b0;
`ifdef AXI_RD_ARB_TIMEOUT_EN
    tmo_cnt_d  = tmo_cnt_q;
    timeout_d  = timeout_q;
    absorb_d   = absorb_q;
`endif
    unique case (state_q)
      IDLE: begin
`ifdef AXI_RD_ARB_TIMEOUT_EN
        if (absorb_q) m_rready = 1'b1;
`endif
        if (pick_found && aresetn) begin
          s_arready[pick_idx] = 1'b1;
          ar_d    = s_ar[pick_idx];
          gnt_d   = pick_idx;
          state_d = ADDR;
`ifdef AXI_RD_ARB_TIMEOUT_EN
          tmo_cnt_d = '0;
          absorb_d  = 1'b0;
`endif
        end
      end
      ADDR: begin
        m_arvalid = 1'b1;
        if (m_arready) begin
          state_d    = DATA;
          beat_cnt_d = '0;
        end
      end
      DATA: begin
        s_rvalid[gnt_q] = m_rvalid;
        m_rready        = s_rready[gnt_q];
        s_r             = m_r;
        if (r_hs) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          // Flag both early and missing rlast; the burst still only ends on rlast.
          if (m_r.last ^ len_match) len_err_d = 1'b1;
          if (m_r.last) begin
            state_d  = IDLE;
            rr_ptr_d = ptr_next;
          end
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef AXI_RD_ARB_TIMEOUT_EN
    if (state_q != IDLE) begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
      if (tmo_cnt_q == TMO_W'(TIMEOUT - 1)) begin
        timeout_d = 1'b1;
        absorb_d  = 1'b1;
        state_d   = IDLE;
        rr_ptr_d  = ptr_next;
      end
    end
`endif
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      gnt_q      <= '0;
      ar_q       <= '0;
      beat_cnt_q <= '0;
      len_err_q  <= 1'b0;
`ifdef AXI_RD_ARB_TIMEOUT_EN
      tmo_cnt_q  <= '0;
      timeout_q  <= 1'b0;
      absorb_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      gnt_q      <= gnt_d;
      ar_q       <= ar_d;
      beat_cnt_q <= beat_cnt_d;
      len_err_q  <= len_err_d;
`ifdef AXI_RD_ARB_TIMEOUT_EN
      tmo_cnt_q  <= tmo_cnt_d;
      timeout_q  <= timeout_d;
      absorb_q   <= absorb_d;
`endif
    end
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed testbench for axi_rd_arbiter with two requesters; the bench plays the LPDDR controller.
// Scenario tasks drive hand-built vectors and compare against hand-computed values.
module tb_axi_rd_arbiter;
  import axi_arb_pkg::*;

  localparam int NUM_REQ = 2;

  logic       aclk = 1'b0;
  logic       aresetn;
  logic [1:0] s_arvalid, s_arready, s_rvalid, s_rready;
  ar_t        s_ar [NUM_REQ];
  r_t         s_r, m_r;
  logic       m_arvalid, m_arready, m_rvalid, m_rready;
  ar_t        m_ar;
  logic [0:0] gnt_idx;
  logic       len_err;
`ifdef AXI_RD_ARB_TIMEOUT_EN
  logic       timeout;
`endif

  int compared   = 0;
  int mismatched = 0;

  always #5 aclk = ~aclk;

  axi_rd_arbiter #(
    .NUM_REQ(NUM_REQ)
`ifdef AXI_RD_ARB_TIMEOUT_EN
    ,
    .TIMEOUT(16)
`endif
  ) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .s_arvalid (s_arvalid),
    .s_arready (s_arready),
    .s_ar      (s_ar),
    .s_rvalid  (s_rvalid),
    .s_rready  (s_rready),
    .s_r       (s_r),
    .m_arvalid (m_arvalid),
    .m_arready (m_arready),
    .m_ar      (m_ar),
    .m_rvalid  (m_rvalid),
    .m_rready  (m_rready),
    .m_r       (m_r),
    .gnt_idx   (gnt_idx),
    .len_err   (len_err)
`ifdef AXI_RD_ARB_TIMEOUT_EN
    ,
    .timeout   (timeout)
`endif
  );

  // Inputs always change 1 time unit after the rising edge.
  task automatic stepClock();
    @(posedge aclk);
    #1;
  endtask

  function automatic ar_t make_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
    ar_t a;
    a       = '0;
    a.id    = id;
    a.addr  = addr;
    a.len   = len;
    a.size  = 3'd2;
    a.burst = 2'b01;
    return a;
  endfunction

  task automatic test_reset();
    aresetn   = 1'b0;
    s_arvalid = 2'b11;
    s_rready  = 2'b11;
    m_arready = 1'b1;
    m_rvalid  = 1'b1;
    m_r       = '0;
    m_r.data  = 32'hDEAD;
    repeat (2) @(posedge aclk);
    #1;
    compared++; if (s_arready !== 2'b00) begin mismatched++; $display("[TB] FAIL reset_arready: got %b expected 00", s_arready); end
    compared++; if (s_rvalid !== 2'b00) begin mismatched++; $display("[TB] FAIL reset_rvalid: got %b expected 00", s_rvalid); end
    compared++; if (m_arvalid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_m_arvalid: got %b expected 0", m_arvalid); end
    compared++; if (m_rready !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_m_rready: got %b expected 0", m_rready); end
    compared++; if (gnt_idx !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_gnt_idx: got %h expected 0", gnt_idx); end
    compared++; if (len_err !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_len_err: got %b expected 0", len_err); end
    compared++; if (s_r !== '0) begin mismatched++; $display("[TB] FAIL reset_s_r: got %h expected 0", s_r); end
    s_arvalid = 2'b00;
    s_rready  = 2'b00;
    m_arready = 1'b0;
    m_rvalid  = 1'b0;
    aresetn   = 1'b1;
    stepClock();
  endtask

  task automatic test_single();
    s_ar[0]   = make_ar(4'h1, 32'h100, 8'd3);
    s_arvalid = 2'b01;
    #1;
    compared++; if (s_arready !== 2'b01) begin mismatched++; $display("[TB] FAIL single_arready: got %b expected 01", s_arready); end
    stepClock();
    s_arvalid = 2'b00;
    #1;
    compared++; if (m_arvalid !== 1'b1) begin mismatched++; $display("[TB] FAIL single_m_arvalid: got %b expected 1", m_arvalid); end
    compared++; if (m_ar.addr !== 32'h100) begin mismatched++; $display("[TB] FAIL single_m_ar_addr: got %h expected 100", m_ar.addr); end
    compared++; if (m_ar.len !== 8'd3) begin mismatched++; $display("[TB] FAIL single_m_ar_len: got %0d expected 3", m_ar.len); end
    compared++; if (gnt_idx !== 1'b0) begin mismatched++; $display("[TB] FAIL single_gnt_idx: got %h expected 0", gnt_idx); end
    compared++; if (s_arready !== 2'b00) begin mismatched++; $display("[TB] FAIL single_arready_addr: got %b expected 00", s_arready); end
    m_arready = 1'b1;
    stepClock();
    m_arready = 1'b0;
    s_rready  = 2'b11;
    for (int k = 0; k < 4; k++) begin
      m_rvalid = 1'b1;
      m_r      = '0;
      m_r.id   = 4'h1;
      m_r.data = 32'hA0 + k;
      m_r.last = (k == 3);
      #1;
      compared++; if (s_rvalid !== 2'b01) begin mismatched++; $display("[TB] FAIL single_rvalid beat %0d: got %b expected 01", k, s_rvalid); end
      compared++; if (m_rready !== 1'b1) begin mismatched++; $display("[TB] FAIL single_m_rready beat %0d: got %b expected 1", k, m_rready); end
      compared++; if (s_r.data !== 32'hA0 + k) begin mismatched++; $display("[TB] FAIL single_data beat %0d: got %h expected %h", k, s_r.data, 32'hA0 + k); end
      stepClock();
    end
    #1;
    compared++; if (s_rvalid !== 2'b00) begin mismatched++; $display("[TB] FAIL single_idle_rvalid: got %b expected 00", s_rvalid); end
    compared++; if (m_rready !== 1'b0) begin mismatched++; $display("[TB] FAIL single_idle_m_rready: got %b expected 0", m_rready); end
    compared++; if (len_err !== 1'b0) begin mismatched++; $display("[TB] FAIL single_len_err: got %b expected 0", len_err); end
    m_rvalid = 1'b0;
    s_rready = 2'b00;
  endtask

  task automatic test_contention();
    aresetn   = 1'b0;
    s_ar[0]   = make_ar(4'h0, 32'h1000, 8'd0);
    s_ar[1]   = make_ar(4'h1, 32'h2000, 8'd0);
    s_arvalid = 2'b11;
    stepClock();
    aresetn = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      logic       exp_idx;
      logic [1:0] exp_oh;
      exp_idx = (i % 2 == 1);
      exp_oh  = exp_idx ? 2'b10 : 2'b01;
      compared++; if (s_arready !== exp_oh) begin mismatched++; $display("[TB] FAIL contention_arready %0d: got %b expected %b", i, s_arready, exp_oh); end
      stepClock();
      #1;
      compared++; if (gnt_idx !== exp_idx) begin mismatched++; $display("[TB] FAIL contention_gnt_idx %0d: got %h expected %h", i, gnt_idx, exp_idx); end
      compared++; if (m_ar.addr !== (exp_idx ? 32'h2000 : 32'h1000)) begin mismatched++; $display("[TB] FAIL contention_addr %0d: got %h", i, m_ar.addr); end
      compared++; if (s_arready !== 2'b00) begin mismatched++; $display("[TB] FAIL contention_busy_arready %0d: got %b expected 00", i, s_arready); end
      m_arready = 1'b1;
      stepClock();
      m_arready = 1'b0;
      m_rvalid  = 1'b1;
      m_r       = '0;
      m_r.last  = 1'b1;
      s_rready  = 2'b11;
      #1;
      compared++; if (s_rvalid !== exp_oh) begin mismatched++; $display("[TB] FAIL contention_rvalid %0d: got %b expected %b", i, s_rvalid, exp_oh); end
      stepClock();
      m_rvalid = 1'b0;
      #1;
    end
    s_arvalid = 2'b00;
    s_rready  = 2'b00;
    compared++; if (len_err !== 1'b0) begin mismatched++; $display("[TB] FAIL contention_len_err: got %b expected 0", len_err); end
  endtask

  task automatic test_backpressure();
    int   beat;
    int   cyc;
    logic stall;
    s_ar[1]   = make_ar(4'h2, 32'h3000, 8'd7);
    s_arvalid = 2'b10;
    #1;
    compared++; if (s_arready !== 2'b10) begin mismatched++; $display("[TB] FAIL bp_arready: got %b expected 10", s_arready); end
    stepClock();
    s_arvalid = 2'b00;
    m_arready = 1'b1;
    stepClock();
    m_arready = 1'b0;
    beat = 0;
    cyc  = 0;
    while (beat < 8 && cyc < 40) begin
      stall    = (cyc >= 3 && cyc < 8);
      m_rvalid = 1'b1;
      m_r      = '0;
      m_r.id   = 4'h2;
      m_r.data = 32'h300 + beat;
      m_r.last = (beat == 7);
      s_rready = stall ? 2'b01 : 2'b11;
      #1;
      compared++; if (m_rready !== !stall) begin mismatched++; $display("[TB] FAIL bp_m_rready cyc %0d: got %b expected %b", cyc, m_rready, !stall); end
      compared++; if (s_rvalid !== 2'b10) begin mismatched++; $display("[TB] FAIL bp_rvalid cyc %0d: got %b expected 10", cyc, s_rvalid); end
      compared++; if (s_r.data !== 32'h300 + beat) begin mismatched++; $display("[TB] FAIL bp_data cyc %0d: got %h expected %h", cyc, s_r.data, 32'h300 + beat); end
      stepClock();
      if (!stall) beat++;
      cyc++;
    end
    compared++; if (cyc >= 40) begin mismatched++; $display("[TB] FAIL bp_bound: got %0d beats expected 8 within 40 cycles", beat); end
    #1;
    compared++; if (s_rvalid !== 2'b00) begin mismatched++; $display("[TB] FAIL bp_idle_rvalid: got %b expected 00", s_rvalid); end
    compared++; if (len_err !== 1'b0) begin mismatched++; $display("[TB] FAIL bp_len_err: got %b expected 0", len_err); end
    m_rvalid = 1'b0;
    s_rready = 2'b00;
  endtask

  task automatic test_len_mismatch();
    s_ar[0]   = make_ar(4'h3, 32'h4000, 8'd3);
    s_arvalid = 2'b01;
    #1;
    compared++; if (s_arready !== 2'b01) begin mismatched++; $display("[TB] FAIL lenmis_arready: got %b expected 01", s_arready); end
    stepClock();
    s_arvalid = 2'b00;
    m_arready = 1'b1;
    stepClock();
    m_arready = 1'b0;
    s_rready  = 2'b01;
    for (int k = 0; k < 3; k++) begin
      m_rvalid = 1'b1;
      m_r      = '0;
      m_r.data = k;
      m_r.last = (k == 2);
      #1;
      compared++; if (len_err !== 1'b0) begin mismatched++; $display("[TB] FAIL lenmis_early beat %0d: got %b expected 0", k, len_err); end
      stepClock();
    end
    #1;
    compared++; if (len_err !== 1'b1) begin mismatched++; $display("[TB] FAIL lenmis_set: got %b expected 1", len_err); end
    compared++; if (s_rvalid !== 2'b00) begin mismatched++; $display("[TB] FAIL lenmis_ended: got %b expected 00", s_rvalid); end
    m_rvalid  = 1'b0;
    s_ar[0]   = make_ar(4'h4, 32'h5000, 8'd1);
    s_arvalid = 2'b01;
    #1;
    compared++; if (s_arready !== 2'b01) begin mismatched++; $display("[TB] FAIL lenmis_next_arready: got %b expected 01", s_arready); end
    stepClock();
    s_arvalid = 2'b00;
    #1;
    compared++; if (m_ar.addr !== 32'h5000) begin mismatched++; $display("[TB] FAIL lenmis_next_addr: got %h expected 5000", m_ar.addr); end
    m_arready = 1'b1;
    stepClock();
    m_arready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      m_rvalid = 1'b1;
      m_r      = '0;
      m_r.data = 32'h50 + k;
      m_r.last = (k == 1);
      #1;
      compared++; if (s_rvalid !== 2'b01) begin mismatched++; $display("[TB] FAIL lenmis_next_rvalid beat %0d: got %b expected 01", k, s_rvalid); end
      stepClock();
    end
    m_rvalid = 1'b0;
    #1;
    compared++; if (len_err !== 1'b1) begin mismatched++; $display("[TB] FAIL lenmis_sticky: got %b expected 1", len_err); end
    s_rready = 2'b00;
  endtask

  task automatic test_reset_mid_data();
    s_ar[1]   = make_ar(4'h5, 32'h6000, 8'd7);
    s_ar[0]   = make_ar(4'h6, 32'h7000, 8'd0);
    s_arvalid = 2'b10;
    #1;
    compared++; if (s_arready !== 2'b10) begin mismatched++; $display("[TB] FAIL rstmid_arready: got %b expected 10", s_arready); end
    stepClock();
    s_arvalid = 2'b00;
    m_arready = 1'b1;
    stepClock();
    m_arready = 1'b0;
    s_rready  = 2'b10;
    for (int k = 0; k < 2; k++) begin
      m_rvalid = 1'b1;
      m_r      = '0;
      m_r.data = k;
      stepClock();
    end
    m_r.data  = 32'h2;
    aresetn   = 1'b0;
    s_arvalid = 2'b11;
    stepClock();
    #1;
    compared++; if (s_rvalid !== 2'b00) begin mismatched++; $display("[TB] FAIL rstmid_rvalid: got %b expected 00", s_rvalid); end
    compared++; if (m_rready !== 1'b0) begin mismatched++; $display("[TB] FAIL rstmid_m_rready: got %b expected 0", m_rready); end
    compared++; if (m_arvalid !== 1'b0) begin mismatched++; $display("[TB] FAIL rstmid_m_arvalid: got %b expected 0", m_arvalid); end
    compared++; if (s_arready !== 2'b00) begin mismatched++; $display("[TB] FAIL rstmid_arready_held: got %b expected 00", s_arready); end
    compared++; if (gnt_idx !== 1'b0) begin mismatched++; $display("[TB] FAIL rstmid_gnt_idx: got %h expected 0", gnt_idx); end
    compared++; if (len_err !== 1'b0) begin mismatched++; $display("[TB] FAIL rstmid_len_err: got %b expected 0", len_err); end
    compared++; if (s_r !== '0) begin mismatched++; $display("[TB] FAIL rstmid_s_r: got %h expected 0", s_r); end
    aresetn  = 1'b1;
    m_rvalid = 1'b0;
    #1;
    compared++; if (s_arready !== 2'b01) begin mismatched++; $display("[TB] FAIL rstmid_ptr0: got %b expected 01", s_arready); end
    stepClock();
    s_arvalid = 2'b00;
    #1;
    compared++; if (m_ar.addr !== 32'h7000) begin mismatched++; $display("[TB] FAIL rstmid_addr: got %h expected 7000", m_ar.addr); end
    m_arready = 1'b1;
    stepClock();
    m_arready = 1'b0;
    s_rready  = 2'b01;
    m_rvalid  = 1'b1;
    m_r       = '0;
    stepClock();
    #1;
    compared++; if (len_err !== 1'b1) begin mismatched++; $display("[TB] FAIL overrun_len_err: got %b expected 1", len_err); end
    compared++; if (s_rvalid !== 2'b01) begin mismatched++; $display("[TB] FAIL overrun_still_data: got %b expected 01", s_rvalid); end
    m_r.last = 1'b1;
    stepClock();
    m_rvalid = 1'b0;
    #1;
    compared++; if (s_rvalid !== 2'b00) begin mismatched++; $display("[TB] FAIL overrun_ended: got %b expected 00", s_rvalid); end
    s_rready = 2'b00;
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_ar, exp_rv;
    logic       exp_mav;
    s_ar[1]   = make_ar(4'h7, 32'h8000, 8'd0);
    s_arvalid = 2'b10;
    m_arready = 1'b1;
    m_rvalid  = 1'b1;
    m_r       = '0;
    m_r.last  = 1'b1;
    s_rready  = 2'b10;
    for (int c = 0; c < 6; c++) begin
      exp_ar  = (c % 3 == 0) ? 2'b10 : 2'b00;
      exp_mav = (c % 3 == 1);
      exp_rv  = (c % 3 == 2) ? 2'b10 : 2'b00;
      #1;
      compared++; if (s_arready !== exp_ar) begin mismatched++; $display("[TB] FAIL b2b_arready c%0d: got %b expected %b", c, s_arready, exp_ar); end
      compared++; if (m_arvalid !== exp_mav) begin mismatched++; $display("[TB] FAIL b2b_m_arvalid c%0d: got %b expected %b", c, m_arvalid, exp_mav); end
      compared++; if (s_rvalid !== exp_rv) begin mismatched++; $display("[TB] FAIL b2b_rvalid c%0d: got %b expected %b", c, s_rvalid, exp_rv); end
      stepClock();
    end
    s_arvalid = 2'b00;
    m_arready = 1'b0;
    m_rvalid  = 1'b0;
    s_rready  = 2'b00;
  endtask

`ifdef AXI_RD_ARB_TIMEOUT_EN
  task automatic test_timeout();
    aresetn = 1'b0;
    stepClock();
    aresetn   = 1'b1;
    s_ar[0]   = make_ar(4'h8, 32'h9000, 8'd3);
    s_ar[1]   = make_ar(4'h9, 32'hA000, 8'd0);
    s_arvalid = 2'b11;
    m_rvalid  = 1'b0;
    #1;
    compared++; if (s_arready !== 2'b01) begin mismatched++; $display("[TB] FAIL tmo_arready: got %b expected 01", s_arready); end
    stepClock();
    for (int k = 1; k <= 16; k++) begin
      m_arready = (k == 1);
      if (k == 16) begin
        #1;
        compared++; if (timeout !== 1'b0) begin mismatched++; $display("[TB] FAIL tmo_early: got %b expected 0", timeout); end
      end
      stepClock();
    end
    m_arready = 1'b0;
    #1;
    compared++; if (timeout !== 1'b1) begin mismatched++; $display("[TB] FAIL tmo_set: got %b expected 1", timeout); end
    compared++; if (s_arready !== 2'b10) begin mismatched++; $display("[TB] FAIL tmo_next_grant: got %b expected 10", s_arready); end
    compared++; if (m_rready !== 1'b1) begin mismatched++; $display("[TB] FAIL tmo_absorb: got %b expected 1", m_rready); end
    s_arvalid = 2'b00;
    stepClock();
  endtask
`endif

  initial begin
    aresetn   = 1'b0;
    s_arvalid = '0;
    s_rready  = '0;
    s_ar[0]   = '0;
    s_ar[1]   = '0;
    m_arready = 1'b0;
    m_rvalid  = 1'b0;
    m_r       = '0;
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_len_mismatch();
    test_reset_mid_data();
    test_back_to_back();
`ifdef AXI_RD_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation still running at time %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
